// File: rtl/store_data_align.sv
// Store data aligner: masks SB/SH/SW data, lane-aligns it, generates byte enables and
//   runs the data-memory req/gnt/ack handshake, splitting word-crossing stores in two.
// Latency: accept N -> req N+1; best case done at N+3 (aligned) or N+5 (split); error at N+1.
// Backpressure: st_ready_out is high only in IDLE; memory stalls via mem_gnt_in / mem_rvalid_in.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   st_valid_in/st_ready_out            store handshake from execute
//   func3_in, addr_in, data_in          store width, byte address, LSB-justified data
//   mem_req_out/mem_gnt_in              memory request / grant
//   mem_addr_out, mem_we_out,
//   mem_be_out, mem_wdata_out           word-aligned request fields (zero when not requesting)
//   mem_rvalid_in                       write acknowledge
//   st_done_out, st_err_out             completion / illegal-width pulses
module store_data_align #(
  parameter int ARCH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid_in,
  output logic              st_ready_out,
  input  logic [2:0]        func3_in,
  input  logic [ARCH-1:0]   addr_in,
  input  logic [ARCH-1:0]   data_in,
  output logic              mem_req_out,
  input  logic              mem_gnt_in,
  output logic [ARCH-1:0]   mem_addr_out,
  output logic              mem_we_out,
  output logic [ARCH/8-1:0] mem_be_out,
  output logic [ARCH-1:0]   mem_wdata_out,
  input  logic              mem_rvalid_in,
  output logic              st_done_out,
  output logic              st_err_out
);

  localparam int BEW = ARCH / 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    ACK0,
    REQ1,
    ACK1,
    DONE,
    ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ARCH-1:0]       addr_q, addr_d;     // word-aligned address of access 0
  logic [2*ARCH-1:0]     wide_q, wide_d;     // data shifted across two words
  logic [2*BEW-1:0]      be_q, be_d;         // byte enables across two words
  logic                  split_q, split_d;

  // Input-side alignment, only used at capture time.
  logic [ARCH-1:0]       masked;
  logic [2*BEW-1:0]      be_base;
  logic                  legal;
  logic [1:0]            offset;
  logic [2*ARCH-1:0]     wide_in;
  logic [2*BEW-1:0]      be_in;

  always_comb begin
    masked  = '0;
    be_base = '0;
    legal   = 1'b1;
    offset  = addr_in[1:0];
    case (func3_in)
      3'd0: begin
        masked[7:0] = data_in[7:0];
        be_base     = (2*BEW)'(4'b0001);
      end
      3'd1: begin
        masked[15:0] = data_in[15:0];
        be_base      = (2*BEW)'(4'b0011);
      end
      3'd2: begin
        masked  = data_in;
        be_base = (2*BEW)'(4'b1111);
      end
      default: legal = 1'b0;
    endcase
    wide_in = (2*ARCH)'(masked) << {offset, 3'b000};
    be_in   = be_base << offset;
  end

  // Next-state and capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wide_d  = wide_q;
    be_d    = be_q;
    split_d = split_q;
    case (state_q)
      IDLE: begin
        if (st_valid_in) begin
          if (legal) begin
            addr_d  = {addr_in[ARCH-1:2], 2'b00};
            wide_d  = wide_in;
            be_d    = be_in;
            // Any enable landing in the upper word means the store crosses a word boundary.
            split_d = |be_in[2*BEW-1:BEW];
            state_d = REQ0;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ0:    if (mem_gnt_in) state_d = ACK0;
      ACK0:    if (mem_rvalid_in) state_d = split_q ? REQ1 : DONE;
      REQ1:    if (mem_gnt_in) state_d = ACK1;
      ACK1:    if (mem_rvalid_in) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wide_q  <= '0;
      be_q    <= '0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wide_q  <= wide_d;
      be_q    <= be_d;
      split_q <= split_d;
    end
  end

  // Outputs decoded from state and registered fields only, so they stay stable
  // while a request waits for grant and drop at once on asynchronous reset.
  always_comb begin
    st_ready_out  = (state_q == IDLE);
    st_done_out   = (state_q == DONE);
    st_err_out    = (state_q == ERR);
    mem_req_out   = 1'b0;
    mem_addr_out  = '0;
    mem_be_out    = '0;
    mem_wdata_out = '0;
    case (state_q)
      REQ0: begin
        mem_req_out   = 1'b1;
        mem_addr_out  = addr_q;
        mem_be_out    = be_q[BEW-1:0];
        mem_wdata_out = wide_q[ARCH-1:0];
      end
      REQ1: begin
        mem_req_out   = 1'b1;
        mem_addr_out  = addr_q + ARCH'(4);
        mem_be_out    = be_q[2*BEW-1:BEW];
        mem_wdata_out = wide_q[2*ARCH-1:ARCH];
      end
      default: ;
    endcase
    mem_we_out = mem_req_out;
  end

endmodule

// File: tb/tb_store_data_align.sv
module tb_store_data_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid_in;
  logic        st_ready_out;
  logic [2:0]  func3_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        mem_req_out;
  logic        mem_gnt_in;
  logic [31:0] mem_addr_out;
  logic        mem_we_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_wdata_out;
  logic        mem_rvalid_in;
  logic        st_done_out;
  logic        st_err_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_data_align #(.ARCH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid_in  (st_valid_in),
    .st_ready_out (st_ready_out),
    .func3_in     (func3_in),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .mem_req_out  (mem_req_out),
    .mem_gnt_in   (mem_gnt_in),
    .mem_addr_out (mem_addr_out),
    .mem_we_out   (mem_we_out),
    .mem_be_out   (mem_be_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_rvalid_in(mem_rvalid_in),
    .st_done_out  (st_done_out),
    .st_err_out   (st_err_out)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          nacc;
    logic        err;
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[9];
  vec_t v_sw_dly;
  vec_t v_sh_split;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle-exact run of one store: memory grants after gdly waiting cycles and acks
  // the cycle after grant. Any extra or missing cycle shows up as a field miscompare.
  task automatic run_store(input vec_t v, input int gdly);
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    chk("ready_before_accept", st_ready_out, 1);
    st_valid_in = 1'b1;
    func3_in    = v.f3;
    addr_in     = v.addr;
    data_in     = v.data;
    step();
    st_valid_in = 1'b0;
    func3_in    = 3'd0;
    addr_in     = 32'h0;
    data_in     = 32'h0;
    if (v.err) begin
      chk("err_pulse", st_err_out, 1);
      chk("err_no_req", mem_req_out, 0);
      chk("err_ready_low", st_ready_out, 0);
      step();
      chk("err_pulse_end", st_err_out, 0);
      chk("err_ready_back", st_ready_out, 1);
      chk("err_no_req_after", mem_req_out, 0);
    end else begin
      for (int k = 0; k < v.nacc; k++) begin
        ea = (k == 0) ? v.a0 : v.a1;
        eb = (k == 0) ? v.b0 : v.b1;
        ew = (k == 0) ? v.w0 : v.w1;
        for (int d = 0; d <= gdly; d++) begin
          chk("req_high", mem_req_out, 1);
          chk("we_eq_req", mem_we_out, 1);
          chk("req_addr", mem_addr_out, ea);
          chk("req_be", mem_be_out, eb);
          chk("req_wdata", mem_wdata_out, ew);
          chk("ready_busy", st_ready_out, 0);
          chk("no_early_done", st_done_out, 0);
          mem_gnt_in = (d == gdly);
          step();
        end
        mem_gnt_in = 1'b0;
        chk("req_low_in_ack", mem_req_out, 0);
        chk("be_zero_in_ack", mem_be_out, 0);
        chk("no_done_in_ack", st_done_out, 0);
        mem_rvalid_in = 1'b1;
        step();
        mem_rvalid_in = 1'b0;
      end
      chk("done_pulse", st_done_out, 1);
      chk("done_ready_low", st_ready_out, 0);
      chk("done_no_req", mem_req_out, 0);
      step();
      chk("done_pulse_end", st_done_out, 0);
      chk("ready_after_done", st_ready_out, 1);
    end
  endtask

  initial begin
    //            f3    addr           data           n  err a0             b0       w0             a1             b1       w1
    vecs[0] = '{3'd0, 32'h0000_1003, 32'hAABB_CCDD, 1, 0, 32'h0000_1000, 4'b1000, 32'hDD00_0000, 32'h0,         4'b0000, 32'h0};
    vecs[1] = '{3'd1, 32'h0000_1003, 32'h0000_1234, 2, 0, 32'h0000_1000, 4'b1000, 32'h3400_0000, 32'h0000_1004, 4'b0001, 32'h0000_0012};
    vecs[2] = '{3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 1, 0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0};
    vecs[3] = '{3'd3, 32'h0000_4000, 32'h1111_1111, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0};
    vecs[4] = '{3'd1, 32'h0000_2002, 32'hFFFF_5678, 1, 0, 32'h0000_2000, 4'b1100, 32'h5678_0000, 32'h0,         4'b0000, 32'h0};
    vecs[5] = '{3'd0, 32'h0000_0000, 32'h1234_5678, 1, 0, 32'h0000_0000, 4'b0001, 32'h0000_0078, 32'h0,         4'b0000, 32'h0};
    vecs[6] = '{3'd2, 32'hFFFF_FFFD, 32'hA1B2_C3D4, 2, 0, 32'hFFFF_FFFC, 4'b1110, 32'hB2C3_D400, 32'h0000_0000, 4'b0001, 32'h0000_00A1};
    vecs[7] = '{3'd7, 32'h0000_0001, 32'h0000_0001, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0};
    vecs[8] = '{3'd1, 32'h0000_0011, 32'h0000_BEEF, 1, 0, 32'h0000_0010, 4'b0110, 32'h00BE_EF00, 32'h0,         4'b0000, 32'h0};
    v_sw_dly   = '{3'd2, 32'h0000_2002, 32'h1122_3344, 2, 0, 32'h0000_2000, 4'b1100, 32'h3344_0000, 32'h0000_2004, 4'b0011, 32'h0000_1122};
    v_sh_split = vecs[1];

    rst_n         = 1'b0;
    st_valid_in   = 1'b0;
    func3_in      = 3'd0;
    addr_in       = 32'h0;
    data_in       = 32'h0;
    mem_gnt_in    = 1'b0;
    mem_rvalid_in = 1'b0;

    #2;
    chk("rst_ready", st_ready_out, 1);
    chk("rst_req", mem_req_out, 0);
    chk("rst_we", mem_we_out, 0);
    chk("rst_done", st_done_out, 0);
    chk("rst_err", st_err_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_be", mem_be_out, 0);
    chk("rst_wdata", mem_wdata_out, 0);
    step();
    rst_n = 1'b1;
    step();

    // Table: immediate grant and ack
    for (int i = 0; i < 9; i++) run_store(vecs[i], 0);

    // Split word store with grant delayed 3 cycles on each access
    run_store(v_sw_dly, 3);

    // Spurious ack while idle must be ignored
    mem_rvalid_in = 1'b1;
    step();
    mem_rvalid_in = 1'b0;
    chk("spur_ready", st_ready_out, 1);
    chk("spur_req", mem_req_out, 0);
    chk("spur_done", st_done_out, 0);
    chk("spur_err", st_err_out, 0);
    step();
    chk("spur_done_later", st_done_out, 0);

    // Reset while in REQ1
    st_valid_in = 1'b1;
    func3_in    = v_sh_split.f3;
    addr_in     = v_sh_split.addr;
    data_in     = v_sh_split.data;
    step();
    st_valid_in = 1'b0;
    chk("rq1_req0", mem_req_out, 1);
    mem_gnt_in = 1'b1;
    step();
    mem_gnt_in    = 1'b0;
    mem_rvalid_in = 1'b1;
    step();
    mem_rvalid_in = 1'b0;
    chk("rq1_in_req1", mem_req_out, 1);
    chk("rq1_addr1", mem_addr_out, 32'h0000_1004);
    rst_n = 1'b0;
    #1;
    chk("rq1_async_req", mem_req_out, 0);
    chk("rq1_async_ready", st_ready_out, 1);
    chk("rq1_async_be", mem_be_out, 0);
    mem_rvalid_in = 1'b1;
    step();
    chk("rq1_in_rst_done", st_done_out, 0);
    rst_n = 1'b1;
    step();
    mem_rvalid_in = 1'b0;
    chk("rq1_post_done", st_done_out, 0);
    chk("rq1_post_req", mem_req_out, 0);
    chk("rq1_post_ready", st_ready_out, 1);
    step();
    chk("rq1_post_done2", st_done_out, 0);
    run_store(vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
